// File: rtl/slow_pkg.sv
// rtl/slow_pkg.sv - shared types and constants for the slow-mode sequencer
package slow_pkg;

  typedef enum logic [1:0] {
    FAST = 2'd0,
    DOWN = 2'd1,
    SLOW = 2'd2,
    UP   = 2'd3
  } state_e;

  localparam int IACK  = 0;
  localparam int VIA   = 1;
  localparam int IWM   = 2;
  localparam int SCC   = 3;
  localparam int SCSI  = 4;
  localparam int SND   = 5;
  localparam int N_DEV = 6;

  localparam int PRESCALE_DEFAULT = 256;

  function automatic logic slow_hit(input logic [N_DEV-1:0] cs, input logic [N_DEV-1:0] en);
    return |(cs & en);
  endfunction

endpackage

// File: rtl/slow_timer.sv
// rtl/slow_timer.sv - prescaler plus saturating 4-bit idle down-counter
module slow_timer #(
  parameter int PRESCALE = 256,
  parameter int PS_W     = 8
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       Reload,
  input  logic [3:0] Load,
  input  logic       Run,
  output logic       Zero
);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0]      tmr_q, tmr_d;
  logic            wrap;

  assign wrap = (ps_q == PS_W'(PRESCALE - 1));
  assign Zero = (tmr_q == 4'd0);

  always_comb begin
    ps_d  = ps_q;
    tmr_d = tmr_q;
    if (Reload) begin
      ps_d  = '0;
      tmr_d = Load;
    end else if (Run) begin
      ps_d = ps_q + 1'b1;
      if (wrap && tmr_q != 4'd0) tmr_d = tmr_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      ps_q  <= '0;
      tmr_q <= 4'd0;
    end else begin
      ps_q  <= ps_d;
      tmr_q <= tmr_d;
    end
  end

endmodule

// File: rtl/slow_sequencer.sv
// rtl/slow_sequencer.sv - fast/slow clock sequencing for peripheral bus accesses
// Optional SLOW_CLKGATE_EN: drive ClkGateEn from SlowActive & SlowClockGate.
module slow_sequencer
  import slow_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PS_W     = 8
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic [3:0] SlowTimeout,
  input  logic       SlowClockGate,
  input  logic       SlowAck,
  output logic       SlowReq,
  output logic       BusHold,
  output logic       SlowActive,
  output logic       ClkGateEn
);

  state_e           state_q, state_d;
  logic             bactr_q;
  logic             slow_req_q, slow_req_d;
  logic             slow_active_q, slow_active_d;
  logic             clk_gate_q, clk_gate_d;
  logic             bus_hold;
  logic [N_DEV-1:0] cs, en;
  logic             hit, start, tmr_reload, tmr_run, tmr_zero;

  always_comb begin
    cs       = '0;
    en       = '0;
    cs[IACK] = IACKCS;  en[IACK] = SlowIACK;
    cs[VIA]  = VIACS;   en[VIA]  = SlowVIA;
    cs[IWM]  = IWMCS;   en[IWM]  = SlowIWM;
    cs[SCC]  = SCCCS;   en[SCC]  = SlowSCC;
    cs[SCSI] = SCSICS;  en[SCSI] = SlowSCSI;
    cs[SND]  = SndCS;   en[SND]  = SlowSnd;
  end

  assign hit   = BACT & slow_hit(cs, en);
  assign start = BACT & ~bactr_q;

  // Outside SLOW the timer is parked at SlowTimeout so entry always starts a full hold.
  assign tmr_reload = (start & hit) | hit | (state_q != SLOW);
  assign tmr_run    = (state_q == SLOW);

  slow_timer #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_timer (
    .CLK    (CLK),
    .nPOR   (nPOR),
    .Reload (tmr_reload),
    .Load   (SlowTimeout),
    .Run    (tmr_run),
    .Zero   (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    bus_hold = 1'b0;
    case (state_q)
      FAST: if (hit) begin
        state_d  = DOWN;
        bus_hold = 1'b1;
      end
      DOWN: begin
        bus_hold = BACT;
        if (SlowAck) state_d = SLOW;
      end
      SLOW: if (tmr_zero && !hit) state_d = UP;
      UP: begin
        // A hit while still winding up reverses straight back to DOWN.
        if (hit) begin
          state_d  = DOWN;
          bus_hold = 1'b1;
        end else if (!SlowAck) begin
          state_d = FAST;
        end
      end
      default: state_d = FAST;
    endcase
    slow_req_d    = (state_d == DOWN) || (state_d == SLOW);
    slow_active_d = (state_d == SLOW);
  end

`ifdef SLOW_CLKGATE_EN
  assign clk_gate_d = slow_active_q & SlowClockGate & (state_d == SLOW);
`else
  logic unused_clk_gate;
  assign unused_clk_gate = SlowClockGate;
  assign clk_gate_d      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q       <= FAST;
      bactr_q       <= 1'b0;
      slow_req_q    <= 1'b0;
      slow_active_q <= 1'b0;
      clk_gate_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bactr_q       <= BACT;
      slow_req_q    <= slow_req_d;
      slow_active_q <= slow_active_d;
      clk_gate_q    <= clk_gate_d;
    end
  end

  assign SlowReq    = slow_req_q;
  assign BusHold    = bus_hold;
  assign SlowActive = slow_active_q;
  assign ClkGateEn  = clk_gate_q;

endmodule

// File: doc/slow_sequencer.md
Name: slow_sequencer

Overview:
- Sequences the accelerator's fast/slow mode for peripheral accesses.
- On a bus access to a device whose Slow* enable bit is set, it requests slow mode from the clock switcher and holds the CPU bus until the switch is acknowledged.
- It stays slow until a programmable idle timeout expires, then requests fast mode again.
- Consumes the Slow* flags and SlowTimeout from the settings register; drives the clock-switch handshake and the bus wait.

Parameters:
- PRESCALE, 256, CLK cycles per timeout unit (power of two, 2..65536).
- PS_W, 8, prescaler width, equals log2(PRESCALE).

Ports:
- CLK  in  1  system clock.
- nPOR  in  1  asynchronous active-low reset.
- BACT  in  1  CPU bus access active.
- IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS  in  1 each  decoded device selects, valid while BACT.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-device slow enables.
- SlowTimeout  in  4  idle timeout in units of PRESCALE cycles.
- SlowClockGate  in  1  clock-gate enable flag.
- SlowAck  in  1  clock switcher status: 1 = running slow.
- SlowReq  out  1  request slow clock.
- BusHold  out  1  stall the current CPU access.
- SlowActive  out  1  status: state is SLOW.
- ClkGateEn  out  1  gate the fast clock domain.

Behaviour:
- Reset (async, nPOR=0): state FAST; SlowReq, BusHold, SlowActive and ClkGateEn all 0; prescaler and timer cleared; BACTr cleared.
- Hit = BACT & |(each CS & its Slow flag). Evaluated combinationally each cycle.
- Start = BACT & !BACTr, where BACTr is BACT registered.
- States:
  - FAST: SlowReq=0. If Hit, go to DOWN and assert BusHold in the same cycle (combinational from Hit).
  - DOWN: SlowReq=1, BusHold=BACT. When SlowAck=1, go to SLOW. BusHold drops the cycle the state is SLOW.
  - SLOW: SlowReq=1, SlowActive=1.
    - Timer reloads with SlowTimeout on every Start&Hit, and on every cycle that BACT&Hit is true; the prescaler clears on each reload.
    - While no reload occurs, the prescaler counts; on wrap (PRESCALE-1 to 0) the timer decrements, saturating at 0.
    - Timer==0 & !(BACT&Hit): go to UP.
    - SlowTimeout=0 therefore leaves SLOW the first cycle after the hitting access ends.
  - UP: SlowReq=0. When SlowAck=0, go to FAST.
    - If Hit occurs while in UP: BusHold=1 and go to DOWN immediately; SlowReq rises again next cycle. The switcher must tolerate the reversal.
- Non-hit accesses never assert BusHold in any state.
- SlowReq is registered (decoded from state). BusHold is combinational from state, BACT and Hit.
- Config changes take effect immediately, including mid-access. Clearing the relevant Slow flag while in DOWN keeps DOWN; the access has already been committed.
- A new Start&Hit in SLOW reloads the timer with no extra latency.
- Prescaler width is PS_W; the timer is 4 bits, so max hold ≈ 15·PRESCALE cycles after the last hitting access.

Optional Feature:
- SLOW_CLKGATE_EN defined: ClkGateEn = SlowActive & SlowClockGate, registered, one cycle after entering SLOW; cleared on exit from SLOW.
- Not defined: ClkGateEn tied 0. SlowClockGate input is kept but ignored.

Decomposition:
- Package slow_pkg holds:
  - state enum {FAST, DOWN, SLOW, UP}, 2 bits;
  - device index constants (IACK=0 .. SND=5);
  - the PRESCALE default.
- One sub-module, slow_timer: prescaler plus 4-bit down-counter.
  - Ports: CLK, nPOR, Reload, Load[3:0], Run, Zero.
  - Instantiated once; the FSM and hit decode stay in slow_sequencer.

Test Plan:
- Reset: nPOR=0 mid-SLOW → all outputs 0 asynchronously; after release, state FAST.
- VIA access, SlowVIA=1, SlowTimeout=2, PRESCALE=4:
  - Hit → BusHold=1 in the same cycle; SlowReq=1 next cycle.
  - SlowAck after 3 cycles → BusHold=0 and SlowActive=1.
  - After BACT drops, SlowReq falls 8..9 cycles later.
- SCC access, SlowSCC=0 → BusHold, SlowReq and SlowActive stay 0 throughout.
- Back-to-back IWM hits 5 cycles apart in SLOW, SlowTimeout=1, PRESCALE=4 → no exit between accesses; exit 4..5 cycles after the last access.
- Hit while in UP with SlowAck still 1 → BusHold=1, return to DOWN, SlowReq re-asserted the next cycle, no FAST visit.
- SLOW_CLKGATE_EN defined, SlowClockGate=1 → ClkGateEn=1 one cycle after SlowActive rises and 0 on exit.
- Same test without the macro → ClkGateEn=0 throughout.
